// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Optional timeout abort is compiled in with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned TO_CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_ID_I = 1'b0,
        REQ_ID_D = 1'b1
    } req_id_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } wr_fields_t;

    function automatic arb_state_e grant_state(input req_id_e id);
        return (id == REQ_ID_D) ? ST_GRANT_D : ST_GRANT_I;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Grant watchdog: counts un-acked grant cycles and flags the cycle that reaches P_TIMEOUT.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Count,
    output logic o_Expire_c
);

    logic [TO_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cnt <= '0;
        end else if (i_Clear) begin
            r_cnt <= '0;
        end else if (i_Count) begin
            r_cnt <= r_cnt + TO_CNT_W'(1);
        end
    end

    // The P_TIMEOUT-th un-acked grant cycle is the last one; an ack in it takes precedence.
    assign o_Expire_c = i_Count && (r_cnt == TO_CNT_W'(P_TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store buses onto one memory port, data bus first.
// Define MEM_ARB_TIMEOUT_EN to abort grants that see no i_MemAck within P_TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned P_ADDR_W  = 32,
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_IBusReq,
    input  logic [P_ADDR_W-1:0] i_IBusAddr,
    output logic                o_IBusAck,
    output logic [DATA_W-1:0]   o_IBusRData,
    input  logic                i_DBusReq,
    input  logic                i_DBusWe,
    input  logic [P_ADDR_W-1:0] i_DBusAddr,
    input  logic [DATA_W-1:0]   i_DBusWData,
    input  logic [STRB_W-1:0]   i_DBusWStrb,
    output logic                o_DBusAck,
    output logic [DATA_W-1:0]   o_DBusRData,
    output logic                o_MemReq,
    output logic                o_MemWe,
    output logic [P_ADDR_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0]   o_MemWData,
    output logic [STRB_W-1:0]   o_MemWStrb,
    input  logic                i_MemAck,
    input  logic [DATA_W-1:0]   i_MemRData,
    output logic                o_Busy,
    output logic                o_BusErr
);

    arb_state_e          r_state, w_state_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic [P_ADDR_W-1:0] r_addr, w_addr_nxt;
    wr_fields_t          r_wr, w_wr_nxt;
    logic                r_ibus_ack, w_ibus_ack_nxt;
    logic                r_dbus_ack, w_dbus_ack_nxt;
    logic [DATA_W-1:0]   r_ibus_rdata, w_ibus_rdata_nxt;
    logic [DATA_W-1:0]   r_dbus_rdata, w_dbus_rdata_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_bus_err, w_bus_err_nxt;

    req_id_e             w_gnt_id;
    logic                w_timeout;
    logic                w_done;
    logic [DATA_W-1:0]   w_rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_in_grant;
    assign w_in_grant = (r_state == ST_GRANT_I) || (r_state == ST_GRANT_D);

    mem_arb_timeout #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_timeout (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Clear    (!w_in_grant),
        .i_Count    (w_in_grant && !i_MemAck),
        .o_Expire_c (w_timeout)
    );
`else
    assign w_timeout = 1'b0;

    // P_TIMEOUT is only consumed by the watchdog; this empty scope keeps it referenced.
    if (P_TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    assign w_gnt_id   = (r_state == ST_GRANT_D) ? REQ_ID_D : REQ_ID_I;
    assign w_done     = i_MemAck || w_timeout;
    assign w_rsp_data = i_MemAck ? i_MemRData : '0;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_addr_nxt       = r_addr;
        w_wr_nxt         = r_wr;
        w_ibus_ack_nxt   = 1'b0;
        w_dbus_ack_nxt   = 1'b0;
        w_bus_err_nxt    = 1'b0;
        w_ibus_rdata_nxt = r_ibus_rdata;
        w_dbus_rdata_nxt = r_dbus_rdata;

        case (r_state)
            ST_IDLE: begin
                if (i_DBusReq) begin
                    w_state_nxt   = grant_state(REQ_ID_D);
                    w_mem_req_nxt = 1'b1;
                    w_addr_nxt    = i_DBusAddr;
                    w_wr_nxt      = '{we: i_DBusWe, wdata: i_DBusWData, wstrb: i_DBusWStrb};
                end else if (i_IBusReq) begin
                    w_state_nxt   = grant_state(REQ_ID_I);
                    w_mem_req_nxt = 1'b1;
                    w_addr_nxt    = i_IBusAddr;
                    w_wr_nxt      = '{we: 1'b0, wdata: '0, wstrb: '0};
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (w_done) begin
                    w_state_nxt   = ST_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = !i_MemAck;
                    if (w_gnt_id == REQ_ID_D) begin
                        w_dbus_ack_nxt   = 1'b1;
                        w_dbus_rdata_nxt = w_rsp_data;
                    end else begin
                        w_ibus_ack_nxt   = 1'b1;
                        w_ibus_rdata_nxt = w_rsp_data;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_addr       <= '0;
            r_wr         <= '0;
            r_ibus_ack   <= 1'b0;
            r_dbus_ack   <= 1'b0;
            r_ibus_rdata <= '0;
            r_dbus_rdata <= '0;
            r_busy       <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_addr       <= w_addr_nxt;
            r_wr         <= w_wr_nxt;
            r_ibus_ack   <= w_ibus_ack_nxt;
            r_dbus_ack   <= w_dbus_ack_nxt;
            r_ibus_rdata <= w_ibus_rdata_nxt;
            r_dbus_rdata <= w_dbus_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    assign o_IBusAck   = r_ibus_ack;
    assign o_IBusRData = r_ibus_rdata;
    assign o_DBusAck   = r_dbus_ack;
    assign o_DBusRData = r_dbus_rdata;
    assign o_MemReq    = r_mem_req;
    assign o_MemWe     = r_wr.we;
    assign o_MemAddr   = r_addr;
    assign o_MemWData  = r_wr.wdata;
    assign o_MemWStrb  = r_wr.wstrb;
    assign o_Busy      = r_busy;
    assign o_BusErr    = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (pending requests, data priority, per-bus read data).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned MAX_WAIT = 3;
`else
    localparam int unsigned MAX_WAIT = 5;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_IBusReq = 1'b0;
    logic [AW-1:0] i_IBusAddr = '0;
    logic          o_IBusAck;
    logic [31:0]   o_IBusRData;
    logic          i_DBusReq = 1'b0;
    logic          i_DBusWe = 1'b0;
    logic [AW-1:0] i_DBusAddr = '0;
    logic [31:0]   i_DBusWData = '0;
    logic [3:0]    i_DBusWStrb = '0;
    logic          o_DBusAck;
    logic [31:0]   o_DBusRData;
    logic          o_MemReq;
    logic          o_MemWe;
    logic [AW-1:0] o_MemAddr;
    logic [31:0]   o_MemWData;
    logic [3:0]    o_MemWStrb;
    logic          i_MemAck = 1'b0;
    logic [31:0]   i_MemRData = '0;
    logic          o_Busy;
    logic          o_BusErr;

    mem_port_arbiter #(
        .P_ADDR_W  (AW),
        .P_TIMEOUT (4)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_IBusReq   (i_IBusReq),
        .i_IBusAddr  (i_IBusAddr),
        .o_IBusAck   (o_IBusAck),
        .o_IBusRData (o_IBusRData),
        .i_DBusReq   (i_DBusReq),
        .i_DBusWe    (i_DBusWe),
        .i_DBusAddr  (i_DBusAddr),
        .i_DBusWData (i_DBusWData),
        .i_DBusWStrb (i_DBusWStrb),
        .o_DBusAck   (o_DBusAck),
        .o_DBusRData (o_DBusRData),
        .o_MemReq    (o_MemReq),
        .o_MemWe     (o_MemWe),
        .o_MemAddr   (o_MemAddr),
        .o_MemWData  (o_MemWData),
        .o_MemWStrb  (o_MemWStrb),
        .i_MemAck    (i_MemAck),
        .i_MemRData  (i_MemRData),
        .o_Busy      (o_Busy),
        .o_BusErr    (o_BusErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding requests, their payloads, last data returned per bus.
    bit          ip, dp;
    logic [31:0] m_iaddr, m_daddr, m_dwdata;
    logic        m_dwe;
    logic [3:0]  m_dstrb;
    logic [31:0] exp_irdata, exp_drdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".memreq"}, 64'(o_MemReq), 64'(0));
        chk({tag, ".iack"},   64'(o_IBusAck), 64'(0));
        chk({tag, ".dack"},   64'(o_DBusAck), 64'(0));
        chk({tag, ".busy"},   64'(o_Busy), 64'(0));
        chk({tag, ".err"},    64'(o_BusErr), 64'(0));
        chk({tag, ".irdata"}, 64'(o_IBusRData), 64'(exp_irdata));
        chk({tag, ".drdata"}, 64'(o_DBusRData), 64'(exp_drdata));
    endtask

    task automatic present_i(input logic [31:0] addr);
        ip = 1'b1; m_iaddr = addr;
        i_IBusReq = 1'b1; i_IBusAddr = addr;
    endtask

    task automatic present_d(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        dp = 1'b1; m_dwe = we; m_daddr = addr; m_dwdata = wdata; m_dstrb = strb;
        i_DBusReq = 1'b1; i_DBusWe = we; i_DBusAddr = addr;
        i_DBusWData = wdata; i_DBusWStrb = strb;
    endtask

    // One full transaction starting from IDLE with at least one request pending.
    task automatic serve(input string tag, input int wait_n, input logic [31:0] rdata,
                         input bit perturb, input bit stray_in_resp);
        bit          is_d;
        logic [31:0] ea, ewd;
        logic        ewe;
        logic [3:0]  est;
        is_d = dp;
        ea   = is_d ? m_daddr : m_iaddr;
        ewe  = is_d ? m_dwe : 1'b0;
        ewd  = is_d ? m_dwdata : 32'h0;
        est  = is_d ? m_dstrb : 4'h0;
        step();
        chk({tag, ".g.memreq"}, 64'(o_MemReq), 64'(1));
        chk({tag, ".g.busy"},   64'(o_Busy), 64'(1));
        chk({tag, ".g.addr"},   64'(o_MemAddr), 64'(ea));
        chk({tag, ".g.we"},     64'(o_MemWe), 64'(ewe));
        chk({tag, ".g.wdata"},  64'(o_MemWData), 64'(ewd));
        chk({tag, ".g.wstrb"},  64'(o_MemWStrb), 64'(est));
        for (int k = 0; k < wait_n; k++) begin
            if (perturb) begin
                if (is_d) begin
                    i_DBusAddr = ea ^ 32'h100; i_DBusWData = ~ewd; i_DBusWe = ~ewe;
                end else begin
                    i_IBusAddr = ea ^ 32'h100;
                end
            end
            step();
            chk({tag, ".w.memreq"}, 64'(o_MemReq), 64'(1));
            chk({tag, ".w.addr"},   64'(o_MemAddr), 64'(ea));
            chk({tag, ".w.wdata"},  64'(o_MemWData), 64'(ewd));
            chk({tag, ".w.we"},     64'(o_MemWe), 64'(ewe));
            chk({tag, ".w.acks"},   64'({o_IBusAck, o_DBusAck}), 64'(0));
            chk({tag, ".w.err"},    64'(o_BusErr), 64'(0));
        end
        i_MemAck = 1'b1; i_MemRData = rdata;
        step();
        i_MemAck = 1'b0;
        if (is_d) exp_drdata = rdata; else exp_irdata = rdata;
        chk({tag, ".r.memreq"}, 64'(o_MemReq), 64'(0));
        chk({tag, ".r.iack"},   64'(o_IBusAck), 64'(!is_d));
        chk({tag, ".r.dack"},   64'(o_DBusAck), 64'(is_d));
        chk({tag, ".r.irdata"}, 64'(o_IBusRData), 64'(exp_irdata));
        chk({tag, ".r.drdata"}, 64'(o_DBusRData), 64'(exp_drdata));
        chk({tag, ".r.err"},    64'(o_BusErr), 64'(0));
        chk({tag, ".r.busy"},   64'(o_Busy), 64'(1));
        if (is_d) begin dp = 1'b0; i_DBusReq = 1'b0; end
        else      begin ip = 1'b0; i_IBusReq = 1'b0; end
        if (stray_in_resp) begin i_MemAck = 1'b1; i_MemRData = $urandom; end
        step();
        i_MemAck = 1'b0;
        check_idle({tag, ".post"});
    endtask

    task automatic reset_model();
        ip = 1'b0; dp = 1'b0;
        i_IBusReq = 1'b0; i_DBusReq = 1'b0;
        exp_irdata = '0; exp_drdata = '0;
    endtask

    initial begin
        reset_model();
        #1;
        check_idle("reset");
        chk("reset.addr", 64'(o_MemAddr), 64'(0));
        chk("reset.wstrb", 64'(o_MemWStrb), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_idle("released");

        // Fetch only, late ack.
        present_i(32'h100);
        serve("ibus", 2, 32'hDEADBEEF, 1'b0, 1'b0);

        // Simultaneous requests: data first, address change during grant ignored.
        present_i(32'h104);
        present_d(1'b1, 32'h200, 32'h55AA, 4'hF);
        serve("both.d", 2, 32'h0000_1111, 1'b1, 1'b0);
        chk("both.ipending", 64'(ip), 64'(1));
        serve("both.i", 1, 32'hCAFE0001, 1'b0, 1'b0);

        // Stray ack while idle.
        i_MemAck = 1'b1; i_MemRData = 32'hBAD0BAD0;
        step();
        i_MemAck = 1'b0;
        check_idle("stray");
        step();
        check_idle("stray2");

        // Asynchronous reset two cycles into a grant.
        present_d(1'b0, 32'h400, 32'h0, 4'h0);
        step();
        chk("rst.grant", 64'(o_MemReq), 64'(1));
        step();
        #3 rst_n = 1'b0;
        #1;
        reset_model();
        check_idle("rst.async");
        chk("rst.addr", 64'(o_MemAddr), 64'(0));
        chk("rst.fields", 64'({o_MemWe, o_MemWData, o_MemWStrb}), 64'(0));
        step();
        #1 rst_n = 1'b1;
        present_i(32'h180);
        serve("after_rst", 1, 32'h12345678, 1'b0, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: abort after four grant cycles.
        present_d(1'b0, 32'h500, 32'h0, 4'h0);
        step();
        chk("to.g1", 64'(o_MemReq), 64'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("to.wait.memreq", 64'(o_MemReq), 64'(1));
            chk("to.wait.err", 64'({o_BusErr, o_DBusAck}), 64'(0));
        end
        step();
        exp_drdata = 32'h0;
        chk("to.err", 64'(o_BusErr), 64'(1));
        chk("to.dack", 64'(o_DBusAck), 64'(1));
        chk("to.rdata", 64'(o_DBusRData), 64'(0));
        chk("to.memreq", 64'(o_MemReq), 64'(0));
        dp = 1'b0; i_DBusReq = 1'b0;
        step();
        check_idle("to.post");
        // Ack on the fourth grant cycle wins.
        present_d(1'b0, 32'h504, 32'h0, 4'h0);
        serve("to.ack4", 3, 32'h600DF00D, 1'b0, 1'b0);
`else
        // Without the watchdog a grant waits indefinitely.
        present_d(1'b0, 32'h500, 32'h0, 4'h0);
        serve("stall", 300, 32'h600DF00D, 1'b0, 1'b0);
`endif

        // Randomized traffic.
        for (int r = 0; r < 80; r++) begin
            if (!ip && ($urandom_range(0, 1) == 1)) present_i($urandom);
            if (!dp && ($urandom_range(0, 1) == 1))
                present_d(1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!ip && !dp) begin
                i_MemAck = 1'($urandom); i_MemRData = $urandom;
                step();
                i_MemAck = 1'b0;
                check_idle("rnd.idle");
            end else begin
                serve("rnd", int'($urandom_range(0, MAX_WAIT)), $urandom,
                      1'($urandom), 1'($urandom));
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (ip || dp) serve("drain", 0, $urandom, 1'b0, 1'b0);
        end
        chk("drained", 64'({ip, dp}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter P_ADDR_W, default 32, memory/bus address width in bits.
REQ-002 SHALL have parameter P_TIMEOUT, default 255, cycles without i_MemAck before abort; legal range 1..1023.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports are listed in REQ-004 to REQ-022.
REQ-004 i_Clk  in  1  sole clock, rising edge.
REQ-005 i_Rst_n  in  1  asynchronous active-low reset.
REQ-006 i_IBusReq  in  1  instruction-fetch request, held until o_IBusAck.
REQ-007 i_IBusAddr  in  P_ADDR_W  fetch address.
REQ-008 o_IBusAck  out  1  one-cycle fetch completion pulse.
REQ-009 o_IBusRData  out  32  fetch data, valid with o_IBusAck.
REQ-010 i_DBusReq  in  1  load/store request, held until o_DBusAck.
REQ-011 i_DBusWe  in  1  1 = store, 0 = load.
REQ-012 i_DBusAddr  in  P_ADDR_W  data address.
REQ-013 i_DBusWData  in  32  store data.
REQ-014 i_DBusWStrb  in  4  store byte enables.
REQ-015 o_DBusAck  out  1  one-cycle data completion pulse.
REQ-016 o_DBusRData  out  32  load data, valid with o_DBusAck.
REQ-017 o_MemReq  out  1  shared-port request, held until i_MemAck.
REQ-018 o_MemWe, o_MemAddr, o_MemWData, o_MemWStrb  out  1/P_ADDR_W/32/4  latched transaction fields.
REQ-019 i_MemAck  in  1  memory completion, sampled only while o_MemReq=1.
REQ-020 i_MemRData  in  32  read data, valid with i_MemAck.
REQ-021 o_Busy  out  1  high in any state other than IDLE.
REQ-022 o_BusErr  out  1  one-cycle pulse on timeout abort.

Function
REQ-023 FSM states SHALL be IDLE, GRANT_I, GRANT_D and RESP; all outputs SHALL be registered.
REQ-024 In IDLE, i_DBusReq=1 SHALL move to GRANT_D, else i_IBusReq=1 SHALL move to GRANT_I (fixed data priority); both low SHALL stay in IDLE.
REQ-025 On the IDLE->GRANT edge, the requester's address, we, wdata and strb SHALL be latched; o_MemReq=1 from the next cycle; IBus grants SHALL drive We=0 and WStrb=0.
REQ-026 While in GRANT_*, latched fields SHALL be stable; input changes and the other requester's request SHALL be ignored.
REQ-027 On i_MemAck=1 in GRANT_x, o_MemReq SHALL drop next cycle, i_MemRData SHALL be captured, and the FSM SHALL move to RESP.
REQ-028 In RESP, the granted o_xAck SHALL be 1 for exactly one cycle with o_xRData valid; the next state SHALL be IDLE.
REQ-029 Minimum latency: request in cycle 0, o_MemReq in cycle 1, ack in cycle 1, o_xAck in cycle 2, re-arbitration in cycle 3.
REQ-030 Requesters SHALL drop their request in the o_xAck cycle; RESP SHALL not arbitrate, so no double grant occurs.
REQ-031 i_MemAck outside GRANT_* SHALL be ignored, with no state or output change.
REQ-032 o_xRData SHALL hold its value until the next completion for that requester.

Reset
REQ-033 i_Rst_n=0 SHALL force IDLE immediately, independent of the clock, including mid-transaction.
REQ-034 In reset, every output and RData register SHALL be 0; o_MemReq SHALL drop without waiting for an ack.
REQ-035 After reset release, the first arbitration SHALL occur on the first rising edge with i_Rst_n=1.

Configuration
REQ-036 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL clear on GRANT entry and increment each GRANT cycle without ack.
REQ-037 Under MEM_ARB_TIMEOUT_EN, when the count reaches P_TIMEOUT, o_MemReq SHALL drop, the FSM SHALL go to RESP with RData=0, and o_BusErr SHALL pulse together with o_xAck.
REQ-038 An ack in the same cycle as the timeout SHALL win (normal completion, no error).
REQ-039 Macro undefined: GRANT SHALL wait indefinitely, o_BusErr SHALL be tied 0, and no counter SHALL be instantiated.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the state enum, the 32-bit data width constant, the strobe width and the requester-ID encoding.
REQ-041 The timeout counter SHALL be sub-module mem_arb_timeout, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-042 IBus only, addr 0x100, ack after 3 cycles with data 0xDEADBEEF -> o_IBusAck is one pulse, RData=0xDEADBEEF, o_MemWe=0.
REQ-043 IBus and DBus requests in the same cycle, DBus store 0x55AA to 0x200 with strb 0xF -> DBus is granted first, then IBus; no overlap of o_MemReq.
REQ-044 DBus address changed to 0x300 while in GRANT_D -> o_MemAddr stays 0x200 until the ack.
REQ-045 i_Rst_n pulled low two cycles into a GRANT -> all outputs are 0 immediately and the FSM is IDLE; a new request after release completes normally.
REQ-046 With MEM_ARB_TIMEOUT_EN and P_TIMEOUT=4, no ack is given -> after 4 GRANT cycles, o_BusErr and o_DBusAck pulse together and RData=0; an ack arriving on cycle 4 gives no error.
REQ-047 Stray i_MemAck in IDLE -> no ack, no state change.
